// File: rtl/cache_fm_sched.sv
// cache_fm_sched: arbitrates dirty-evict writes and miss-fill reads onto one far-memory port and returns fills to the TQ
module cache_fm_sched #(
    parameter int ADDR_W       = 28,
    parameter int LINE_W       = 128,
    parameter int ID_W         = 3,
    parameter int WR_DEPTH     = 4,
    parameter int RD_DEPTH     = 4,
    parameter int MAX_RD_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req_valid_q3,
    input  logic [ADDR_W-1:0] wr_req_addr_q3,
    input  logic [LINE_W-1:0] wr_req_data_q3,
    input  logic              rd_req_valid_q3,
    input  logic [ADDR_W-1:0] rd_req_addr_q3,
    input  logic [ID_W-1:0]   rd_req_id_q3,
    output logic              sched_almost_full,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    output logic [ID_W-1:0]   mem_req_id,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    input  logic [ID_W-1:0]   mem_rsp_id,
    output logic              fm2cache_rsp_valid,
    output logic [LINE_W-1:0] fm2cache_rsp_data,
    output logic [ID_W-1:0]   fm2cache_rsp_id
);
    localparam int WP = $clog2(WR_DEPTH);
    localparam int RP = $clog2(RD_DEPTH);
    localparam int BW = $clog2(MAX_RD_BURST + 1);
    localparam logic [WP:0] WR_FULL = (WP+1)'(WR_DEPTH);
    localparam logic [RP:0] RD_FULL = (RP+1)'(RD_DEPTH);
    localparam logic [WP:0] WR_AF = (WP+1)'(WR_DEPTH - 3);
    localparam logic [RP:0] RD_AF = (RP+1)'(RD_DEPTH - 3);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_RD_BURST);

    typedef enum logic [1:0] {IDLE, RD_HOLD, WR_HOLD} state_t;
    state_t state;

    logic [ADDR_W-1:0] wr_addr_mem [WR_DEPTH];
    logic [LINE_W-1:0] wr_data_mem [WR_DEPTH];
    logic [ADDR_W-1:0] rd_addr_mem [RD_DEPTH];
    logic [ID_W-1:0]   rd_id_mem   [RD_DEPTH];
    logic [WP-1:0] wr_rp, wr_wp, wr_head;
    logic [RP-1:0] rd_rp, rd_wp, rd_head;
    logic [WP:0]   wr_cnt, wr_left, wr_cnt_nxt;
    logic [RP:0]   rd_cnt, rd_left, rd_cnt_nxt;
    logic [BW-1:0] burst, burst_nxt;
    logic hs, hs_wr, hs_rd, wr_push, rd_push, hazard, pick_wr, any_req;

    // Handshake, push acceptance, and the post-pop FIFO view used to choose the next request without a bubble
    always_comb begin
        hs         = mem_req_valid && mem_req_ready;
        hs_wr      = hs && state == WR_HOLD;
        hs_rd      = hs && state == RD_HOLD;
        wr_push    = wr_req_valid_q3 && wr_cnt != WR_FULL;
        rd_push    = rd_req_valid_q3 && rd_cnt != RD_FULL;
        wr_left    = wr_cnt - (WP+1)'(hs_wr);
        rd_left    = rd_cnt - (RP+1)'(hs_rd);
        wr_cnt_nxt = wr_left + (WP+1)'(wr_push);
        rd_cnt_nxt = rd_left + (RP+1)'(rd_push);
        wr_head    = wr_rp + WP'(hs_wr);
        rd_head    = rd_rp + RP'(hs_rd);
        burst_nxt  = (hs_wr || wr_cnt == '0) ? '0 : (hs_rd && burst != BURST_MAX) ? burst + 1'b1 : burst;
        hazard     = 1'b0;
        for (int i = 0; i < WR_DEPTH; i++)
            if ((WP+1)'(i) >= (WP+1)'(hs_wr) && (WP+1)'(i) < wr_cnt && wr_addr_mem[wr_rp + WP'(i)] == rd_addr_mem[rd_head])
                hazard = 1'b1;
        hazard     = hazard && rd_left != '0;
        any_req    = wr_left != '0 || rd_left != '0;
        pick_wr    = hazard || wr_left == WR_FULL || (burst_nxt == BURST_MAX && wr_left != '0) || (rd_left == '0 && wr_left != '0);
    end

    // FIFO storage; only accepted pushes write an entry
    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_addr_mem[wr_wp] <= wr_req_addr_q3;
            wr_data_mem[wr_wp] <= wr_req_data_q3;
        end
        if (rd_push) begin
            rd_addr_mem[rd_wp] <= rd_req_addr_q3;
            rd_id_mem[rd_wp]   <= rd_req_id_q3;
        end
    end

    // Pointers, counts, burst counter, request FSM with registered outputs, backpressure and response register
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_rp <= '0;
            wr_wp <= '0;
            wr_cnt <= '0;
            rd_rp <= '0;
            rd_wp <= '0;
            rd_cnt <= '0;
            burst <= '0;
            state <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_wr <= 1'b0;
            mem_req_addr <= '0;
            mem_req_data <= '0;
            mem_req_id <= '0;
            sched_almost_full <= 1'b0;
            fm2cache_rsp_valid <= 1'b0;
            fm2cache_rsp_data <= '0;
            fm2cache_rsp_id <= '0;
        end else begin
            assert (!(wr_req_valid_q3 && wr_cnt == WR_FULL));
            assert (!(rd_req_valid_q3 && rd_cnt == RD_FULL));
            if (wr_push) wr_wp <= wr_wp + 1'b1;
            if (hs_wr) wr_rp <= wr_rp + 1'b1;
            if (rd_push) rd_wp <= rd_wp + 1'b1;
            if (hs_rd) rd_rp <= rd_rp + 1'b1;
            wr_cnt <= wr_cnt_nxt;
            rd_cnt <= rd_cnt_nxt;
            burst <= burst_nxt;
            sched_almost_full <= wr_cnt_nxt > WR_AF || rd_cnt_nxt > RD_AF;
            if (state == IDLE || hs) begin
                state <= !any_req ? IDLE : pick_wr ? WR_HOLD : RD_HOLD;
                mem_req_valid <= any_req;
                mem_req_wr <= pick_wr;
                mem_req_addr <= pick_wr ? wr_addr_mem[wr_head] : any_req ? rd_addr_mem[rd_head] : '0;
                mem_req_data <= pick_wr ? wr_data_mem[wr_head] : '0;
                mem_req_id <= (any_req && !pick_wr) ? rd_id_mem[rd_head] : '0;
            end
            fm2cache_rsp_valid <= mem_rsp_valid;
            fm2cache_rsp_data <= mem_rsp_data;
            fm2cache_rsp_id <= mem_rsp_id;
        end
    end
endmodule

// File: tb/tb_cache_fm_sched.sv
// tb_cache_fm_sched: queue-based reference model, per-cycle compare, directed scenarios and random traffic
module tb_cache_fm_sched;
    localparam int WD = 4;
    localparam int RDD = 4;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst;
    logic wr_req_valid_q3, rd_req_valid_q3, mem_req_ready, mem_rsp_valid;
    logic [27:0] wr_req_addr_q3, rd_req_addr_q3;
    logic [127:0] wr_req_data_q3, mem_rsp_data;
    logic [2:0] rd_req_id_q3, mem_rsp_id;
    logic sched_almost_full, mem_req_valid, mem_req_wr, fm2cache_rsp_valid;
    logic [27:0] mem_req_addr;
    logic [127:0] mem_req_data, fm2cache_rsp_data;
    logic [2:0] mem_req_id, fm2cache_rsp_id;

    cache_fm_sched dut (
        .clk(clk), .rst(rst),
        .wr_req_valid_q3(wr_req_valid_q3), .wr_req_addr_q3(wr_req_addr_q3), .wr_req_data_q3(wr_req_data_q3),
        .rd_req_valid_q3(rd_req_valid_q3), .rd_req_addr_q3(rd_req_addr_q3), .rd_req_id_q3(rd_req_id_q3),
        .sched_almost_full(sched_almost_full),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_id(mem_req_id),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_id(mem_rsp_id),
        .fm2cache_rsp_valid(fm2cache_rsp_valid), .fm2cache_rsp_data(fm2cache_rsp_data), .fm2cache_rsp_id(fm2cache_rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct {logic [27:0] a; logic [127:0] d;} wr_t;
    typedef struct {logic [27:0] a; logic [2:0] id;} rd_t;
    typedef struct {bit wr; logic [27:0] a; int cyc;} iss_t;

    wr_t wq[$];
    rd_t rq[$];
    iss_t log[$];
    bit held = 0, h_wr = 0, m_af = 0, e_rv = 0, m_hs, m_hz, m_pw;
    logic [27:0] h_a = '0;
    logic [127:0] h_d = '0, e_rd = '0;
    logic [2:0] h_id = '0, e_rid = '0;
    int m_burst = 0, cyc = 0;
    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the FIFOs are queues, the held request stays at the queue front until its handshake
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            wq.delete();
            rq.delete();
            m_burst = 0;
            held = 0;
            m_af = 0;
            e_rv = 0;
            e_rd = '0;
            e_rid = '0;
        end else begin
            m_hs = held && mem_req_ready;
            if ((m_hs && h_wr) || wq.size() == 0) m_burst = 0;
            else if (m_hs && m_burst < MAXB) m_burst++;
            if (m_hs) begin
                log.push_back('{h_wr, h_a, cyc});
                if (h_wr) void'(wq.pop_front());
                else void'(rq.pop_front());
            end
            if (!held || m_hs) begin
                m_hz = 0;
                if (rq.size() != 0) foreach (wq[i]) if (wq[i].a == rq[0].a) m_hz = 1;
                m_pw = m_hz || wq.size() == WD || (m_burst == MAXB && wq.size() != 0) || (rq.size() == 0 && wq.size() != 0);
                held = wq.size() != 0 || rq.size() != 0;
                h_wr = m_pw;
                if (m_pw) begin
                    h_a = wq[0].a; h_d = wq[0].d; h_id = '0;
                end else if (held) begin
                    h_a = rq[0].a; h_d = '0; h_id = rq[0].id;
                end
            end
            if (wr_req_valid_q3 && wq.size() < WD) wq.push_back('{wr_req_addr_q3, wr_req_data_q3});
            if (rd_req_valid_q3 && rq.size() < RDD) rq.push_back('{rd_req_addr_q3, rd_req_id_q3});
            m_af = (WD - wq.size() < 3) || (RDD - rq.size() < 3);
            e_rv = mem_rsp_valid;
            e_rd = mem_rsp_data;
            e_rid = mem_rsp_id;
        end
    end

    // Per-cycle compare of every DUT output against the model, away from the active edge
    always @(negedge clk) begin
        check("req_valid", mem_req_valid, held);
        if (held) begin
            check("req_wr", mem_req_wr, h_wr);
            check("req_addr", mem_req_addr, h_a);
            check("req_data", mem_req_data, h_d);
            check("req_id", mem_req_id, h_id);
        end
        check("almost_full", sched_almost_full, m_af);
        check("rsp_valid", fm2cache_rsp_valid, e_rv);
        if (e_rv) begin
            check("rsp_data", fm2cache_rsp_data, e_rd);
            check("rsp_id", fm2cache_rsp_id, e_rid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_req_valid_q3 = 0;
        rd_req_valid_q3 = 0;
        mem_rsp_valid = 0;
    endtask

    task automatic push_wr(input logic [27:0] a);
        wr_req_valid_q3 = 1;
        wr_req_addr_q3 = a;
        wr_req_data_q3 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic push_rd(input logic [27:0] a, input logic [2:0] id);
        rd_req_valid_q3 = 1;
        rd_req_addr_q3 = a;
        rd_req_id_q3 = id;
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        rst = 1;
        log.delete();
    endtask

    initial begin
        rst = 0;
        wr_req_valid_q3 = 0; rd_req_valid_q3 = 0; mem_rsp_valid = 0; mem_req_ready = 1;
        wr_req_addr_q3 = '0; rd_req_addr_q3 = '0; wr_req_data_q3 = '0; rd_req_id_q3 = '0;
        mem_rsp_data = '0; mem_rsp_id = '0;
        tick();
        tick();
        check("reset_req_valid", mem_req_valid, 0);
        check("reset_af", sched_almost_full, 0);
        check("reset_rsp_valid", fm2cache_rsp_valid, 0);
        rst = 1;
        log.delete();

        // single read and its fill response
        push_rd(28'h100, 3'd2);
        tick();
        tick();
        check("single_valid", mem_req_valid, 1);
        check("single_wr", mem_req_wr, 0);
        check("single_addr", mem_req_addr, 28'h100);
        check("single_id", mem_req_id, 3'd2);
        mem_rsp_valid = 1;
        mem_rsp_data = {16{8'hA5}};
        mem_rsp_id = 3'd2;
        tick();
        check("fill_valid", fm2cache_rsp_valid, 1);
        check("fill_data", fm2cache_rsp_data, {16{8'hA5}});
        check("fill_id", fm2cache_rsp_id, 3'd2);
        tick();
        check("fill_pulse", fm2cache_rsp_valid, 0);
        check("single_issued_once", log.size(), 1);

        // simultaneous evict and fill, different lines: read first, write next cycle
        do_reset();
        push_wr(28'h200);
        push_rd(28'h300, 3'd1);
        repeat (6) tick();
        check("simul_count", log.size(), 2);
        if (log.size() == 2) begin
            check("simul_first_rd", {log[0].wr, log[0].a}, {1'b0, 28'h300});
            check("simul_second_wr", {log[1].wr, log[1].a}, {1'b1, 28'h200});
            check("simul_no_bubble", log[1].cyc - log[0].cyc, 1);
        end

        // same-line hazard: the write goes first
        do_reset();
        push_wr(28'h400);
        push_rd(28'h400, 3'd3);
        repeat (6) tick();
        check("hazard_count", log.size(), 2);
        if (log.size() == 2) begin
            check("hazard_first_wr", {log[0].wr, log[0].a}, {1'b1, 28'h400});
            check("hazard_second_rd", {log[1].wr, log[1].a}, {1'b0, 28'h400});
        end

        // stall in RD_HOLD for 5 cycles
        do_reset();
        mem_req_ready = 0;
        push_rd(28'h500, 3'd5);
        tick();
        tick();
        repeat (5) tick();
        check("stall_valid", mem_req_valid, 1);
        check("stall_addr", mem_req_addr, 28'h500);
        check("stall_not_issued", log.size(), 0);
        mem_req_ready = 1;
        tick();
        tick();
        check("stall_issued_once", log.size(), 1);
        check("stall_idle", mem_req_valid, 0);

        // starvation: one write against a stream of reads
        do_reset();
        mem_req_ready = 0;
        push_wr(28'h600);
        push_rd(28'h700, 3'd0);
        tick();
        push_rd(28'h701, 3'd1);
        tick();
        push_rd(28'h702, 3'd2);
        tick();
        push_rd(28'h703, 3'd3);
        tick();
        mem_req_ready = 1;
        tick();
        push_rd(28'h704, 3'd4);
        tick();
        push_rd(28'h705, 3'd5);
        tick();
        repeat (8) tick();
        check("starve_count", log.size(), 7);
        if (log.size() >= 5) begin
            check("starve_rd3", {log[3].wr, log[3].a}, {1'b0, 28'h703});
            check("starve_wr_fifth", {log[4].wr, log[4].a}, {1'b1, 28'h600});
        end

        // almost-full threshold
        do_reset();
        mem_req_ready = 0;
        push_rd(28'h800, 3'd0);
        tick();
        tick();
        check("af_one_entry", sched_almost_full, 0);
        push_rd(28'h810, 3'd1);
        tick();
        check("af_two_entries", sched_almost_full, 1);

        // reset while a request is held
        push_wr(28'h900);
        tick();
        rst = 0;
        tick();
        check("midrst_valid", mem_req_valid, 0);
        check("midrst_af", sched_almost_full, 0);
        check("midrst_rsp", fm2cache_rsp_valid, 0);
        rst = 1;
        mem_req_ready = 1;
        tick();
        tick();
        check("midrst_fifos_empty", mem_req_valid, 0);

        // random traffic with a small address set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) != 0);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            if (!sched_almost_full && $urandom_range(0, 2) == 0) push_wr(28'($urandom_range(0, 7)));
            if (!sched_almost_full && $urandom_range(0, 2) == 0) push_rd(28'($urandom_range(0, 7)), 3'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                mem_rsp_valid = 1;
                mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
                mem_rsp_id = 3'($urandom);
            end
            tick();
        end
        rst = 1;
        mem_req_ready = 1;
        repeat (30) tick();
        check("drain_idle", mem_req_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
